piano_command_transmitter: RTL and testbench
============================================

// Module: piano_command_transmitter
// PURPOSE
//  Sending end of the piano command link: watches four 6-bit track note inputs and, on any change,
//  emits an 8-bit command {track[1:0], note[5:0]} as a UART frame (8N1, LSB first) on oTx.
//  Sits on the CPU/MMIO side and feeds the piano board's command receiver, which updates its track registers.
// PARAMETERS
//  CLKS_PER_BIT  10416  iFpgaClock cycles per UART bit (100 MHz / 9600 baud); legal >= 2
// PORTS
//  iFpgaClock    in   1  system clock, all state on rising edge
//  iFpgaReset    in   1  asynchronous, active-high reset
//  iTrack0       in   6  desired note, track 0 (0 = silence)
//  iTrack1       in   6  desired note, track 1
//  iTrack2       in   6  desired note, track 2
//  iTrack3       in   6  desired note, track 3
//  iHold         in   1  1 = launch no new frame (frame in flight completes)
//  oTx           out  1  serial line, idle high
//  oBusy         out  1  1 while a frame is in flight
//  oDone         out  1  one-cycle pulse on the cycle the stop bit completes
//  oDoneTrack    out  2  track index of the frame just completed, valid with oDone
// BEHAVIOUR
//  Reset (async, immediate): oTx=1, oBusy=0, oDone=0, oDoneTrack=0, FSM=IDLE, lastSent[0..3]=0, rrPtr=0,
//   baud counter=0, bit index=0.
//  Dirty: dirty[i] = (iTrackN != lastSent[i]), combinational, evaluated every cycle.
//  Arbitration: round-robin; search from rrPtr upward mod 4; first dirty track wins; rrPtr <= winner+1 (wraps 3->0).
//  Launch: in IDLE with |dirty && !iHold, on that edge: shift <= {winner, iTrackN}, lastSent[winner] <= iTrackN,
//   latch winner for oDoneTrack, FSM -> START, oTx <= 0, oBusy <= 1.  Latency input change -> oTx low: 1 edge.
//  FSM: IDLE -> START -> DATA(8 bits, bit0 first) -> STOP -> IDLE; each state/bit held exactly CLKS_PER_BIT cycles.
//   Frame = 10*CLKS_PER_BIT cycles (11* with parity).  oTx fully registered, glitch-free.
//  STOP end: oTx=1, oBusy<=0, oDone pulses 1 cycle, FSM -> IDLE.  Next launch no earlier than following edge
//   (>= 1 idle-high cycle between frames).
//  Input changing mid-frame: frame content unaffected (already latched); track becomes dirty again, resent later.
//  Input changing then reverting to lastSent before launch: not dirty, no frame.
//  Several tracks dirty at once: sent one per frame in round-robin order, none starved.
//  iHold rising mid-frame: current frame completes normally; iHold only gates IDLE->START.
//  Reset mid-frame: frame aborted, oTx high immediately; lastSent cleared, so every non-zero track is resent
//   after reset release.
// CONFIGURATION
//  PIANO_TX_PARITY_EN defined: frame is 8E1; after bit7 an extra PARITY state sends ^data (even parity),
//   frame = 11*CLKS_PER_BIT cycles.
//  Not defined: 8N1 as above, no PARITY state synthesized.
// TESTING (CLKS_PER_BIT=4 in bench)
//  1 Reset held, tracks all 0 -> oTx=1, oBusy=0, no oDone for 200 cycles after release.
//  2 iTrack2=6'h15 -> byte 8'h95, oTx: 0,1,0,1,0,1,0,0,1,1 each 4 cycles; oDone at cycle 40 with oDoneTrack=2;
//    with PIANO_TX_PARITY_EN parity bit=0 inserted before stop, oDone at cycle 44.
//  3 iTrack0=1, iTrack1=2, iTrack3=3 same cycle -> frames 8'h01, 8'h42, 8'hC3 in that order; 3 oDone pulses.
//  4 iTrack1: 0->5, then 5->9 during that frame -> frames 8'h45 then 8'h49; final lastSent[1]=9.
//  5 iHold=1, iTrack3=6'h3F -> no frame; iHold=0 -> frame 8'hFF starts next edge.
//  6 iFpgaReset pulse at cycle 17 of frame for iTrack0=7 -> oTx=1 same cycle, oBusy=0; after release frame 8'h07 resent.

Source files
------------

// File: rtl/piano_command_transmitter.sv
// rtl/piano_command_transmitter.sv - piano command link UART transmitter
//
// Purpose: watches four 6-bit track note inputs and, whenever one differs from the
// value last sent for that track, transmits the command byte {track[1:0], note[5:0]}
// as a UART frame (LSB first, idle high). Dirty tracks are served round-robin.
//
// Configuration macro: PIANO_TX_PARITY_EN
//   defined     -> 8E1 frame (even parity bit between bit7 and stop)
//   not defined -> 8N1 frame
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports:
//   iFpgaClock    in   system clock, rising edge
//   iFpgaReset    in   asynchronous active-high reset
//   iTrack0..3    in   desired note per track (0 = silence)
//   iHold         in   1 = do not launch a new frame
//   oTx           out  serial line, idle high, registered
//   oBusy         out  1 while a frame is in flight
//   oDone         out  one-cycle pulse when the stop bit completes
//   oDoneTrack    out  track index of the completed frame, valid with oDone

module piano_command_transmitter #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       iFpgaClock,
  input  logic       iFpgaReset,
  input  logic [5:0] iTrack0,
  input  logic [5:0] iTrack1,
  input  logic [5:0] iTrack2,
  input  logic [5:0] iTrack3,
  input  logic       iHold,
  output logic       oTx,
  output logic       oBusy,
  output logic       oDone,
  output logic [1:0] oDoneTrack
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef PIANO_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [5:0]    note [4];
  logic [5:0]    last_sent [4];
  logic [3:0]    dirty;
  logic          any_dirty;
  logic [1:0]    rr_ptr;
  logic [1:0]    winner;
  logic [1:0]    cur_track;
  logic [7:0]    frame_byte;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
  logic          baud_end;

  assign note[0] = iTrack0;
  assign note[1] = iTrack1;
  assign note[2] = iTrack2;
  assign note[3] = iTrack3;

  always_comb begin
    dirty = '0;
    for (int i = 0; i < 4; i++) begin
      dirty[i] = (note[i] != last_sent[i]);
    end
  end

  assign any_dirty = |dirty;
  assign baud_end  = (baud_cnt == BAUD_LAST);

  // Round-robin pick: first dirty track at or after rr_ptr, wrapping mod 4.
  always_comb begin : pick
    logic       found;
    logic [1:0] cand;
    winner = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && dirty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge iFpgaClock or posedge iFpgaReset) begin
    if (iFpgaReset) begin
      state      <= S_IDLE;
      oTx        <= 1'b1;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oDoneTrack <= 2'd0;
      rr_ptr     <= 2'd0;
      cur_track  <= 2'd0;
      frame_byte <= 8'd0;
      bit_idx    <= 3'd0;
      baud_cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        last_sent[i] <= 6'd0;
      end
    end else begin
      oDone <= 1'b0;
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= 3'd0;
        if (any_dirty && !iHold) begin
          // Latch the command now so later input changes cannot disturb this frame.
          frame_byte        <= {winner, note[winner]};
          last_sent[winner] <= note[winner];
          cur_track         <= winner;
          rr_ptr            <= winner + 2'd1;
          state             <= S_START;
          oTx               <= 1'b0;
          oBusy             <= 1'b1;
        end
      end else if (!baud_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            oTx     <= frame_byte[0];
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef PIANO_TX_PARITY_EN
              oTx   <= ^frame_byte;
              state <= S_PARITY;
`else
              oTx   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              oTx     <= frame_byte[bit_idx + 3'd1];
            end
          end
`ifdef PIANO_TX_PARITY_EN
          S_PARITY: begin
            oTx   <= 1'b1;
            state <= S_STOP;
          end
`endif
          S_STOP: begin
            // Returning to IDLE here guarantees at least one idle-high cycle before the next start bit.
            oBusy      <= 1'b0;
            oDone      <= 1'b1;
            oDoneTrack <= cur_track;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piano_command_transmitter.sv
// tb/tb_piano_command_transmitter.sv - self-checking bench for piano_command_transmitter

module tb_piano_command_transmitter;

  localparam int CPB = 4;
`ifdef PIANO_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] t0 = 6'd0, t1 = 6'd0, t2 = 6'd0, t3 = 6'd0;
  logic       hold = 1'b0;
  logic       tx, busy, done;
  logic [1:0] done_trk;

  piano_command_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .iFpgaClock(clk), .iFpgaReset(rst),
    .iTrack0(t0), .iTrack1(t1), .iTrack2(t2), .iTrack3(t3),
    .iHold(hold), .oTx(tx), .oBusy(busy), .oDone(done), .oDoneTrack(done_trk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int frame_count = 0;
  logic [1:0] last_trk = 2'd0;

  typedef struct packed {logic [1:0] trk; logic [7:0] byt;} exp_t;
  exp_t sb[$];

  typedef struct {int trk; logic [5:0] note; logic [7:0] byt;} vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_track(input int i, input logic [5:0] v);
    case (i)
      0: t0 = v;
      1: t1 = v;
      2: t2 = v;
      default: t3 = v;
    endcase
  endtask

  task automatic expect_frame(input logic [7:0] b);
    exp_t e;
    e.trk = b[7:6];
    e.byt = b;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(n < maxc), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_dut();
    t0 = 6'd0; t1 = 6'd0; t2 = 6'd0; t3 = 6'd0; hold = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Line decoder: samples each bit at its centre, pops the scoreboard per complete frame.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        logic [10:0] bits;
        logic        aborted;
        exp_t        e;
        bits = '0;
        aborted = 1'b0;
        for (int i = 1; i <= (NBITS - 1) * CPB + CPB / 2; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (i % CPB == CPB / 2) bits[i / CPB] = tx;
        end
        if (!aborted) begin
          frame_count++;
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", bits[8:1]);
          end else begin
            e = sb.pop_front();
            chk("frame_byte", 32'(bits[8:1]), 32'(e.byt));
`ifdef PIANO_TX_PARITY_EN
            chk("parity_bit", 32'(bits[9]), 32'(^e.byt));
`endif
            last_trk = e.trk;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      chk("done_track", 32'(done_trk), 32'(last_trk));
      done_count++;
    end
  end

  initial begin
    int bad;
    int d0;
    int f0;
    logic [10:0] wave;

    vecs[0] = '{0, 6'h2A, 8'h2A};
    vecs[1] = '{1, 6'h3F, 8'h7F};
    vecs[2] = '{3, 6'h01, 8'hC1};
    vecs[3] = '{2, 6'h20, 8'hA0};
    vecs[4] = '{0, 6'h00, 8'h00};

    // 1: reset state and quiet line with all tracks silent
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_track", 32'(done_trk), 32'd0);
    #2 rst = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_quiet_200", 32'(bad), 32'd0);

    // 2: exact waveform for track 2 = 0x15
`ifdef PIANO_TX_PARITY_EN
    wave = 11'b10100101010;
`else
    wave = {1'b0, 10'b1100101010};
`endif
    t2 = 6'h15;
    expect_frame(8'h95);
    bad = 0;
    for (int i = 0; i < NBITS * CPB; i++) begin
      @(negedge clk);
      if (tx !== wave[i / CPB] || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("t2_waveform", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_done_track", 32'(done_trk), 32'd2);
    chk("t2_busy_clear", 32'(busy), 32'd0);
    chk("t2_tx_idle", 32'(tx), 32'd1);
    wait_idle(400);

    // 3: three tracks dirty at once, round-robin order from track 0
    reset_dut();
    d0 = done_count;
    t0 = 6'd1; t1 = 6'd2; t3 = 6'd3;
    expect_frame(8'h01);
    expect_frame(8'h42);
    expect_frame(8'hC3);
    wait_idle(600);
    chk("rr_done_pulses", 32'(done_count - d0), 32'd3);

    // 4: track changes mid-frame and is resent afterwards
    reset_dut();
    d0 = done_count;
    t1 = 6'd5;
    expect_frame(8'h45);
    repeat (20) @(negedge clk);
    t1 = 6'd9;
    expect_frame(8'h49);
    wait_idle(600);
    chk("midframe_done_pulses", 32'(done_count - d0), 32'd2);
    f0 = frame_count;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    chk("midframe_no_extra", 32'(bad + frame_count - f0), 32'd0);

    // 5: hold blocks launch, release launches on the next edge
    reset_dut();
    hold = 1'b1;
    t3 = 6'h3F;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("hold_blocks", 32'(bad), 32'd0);
    expect_frame(8'hFF);
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_launch", 32'(tx), 32'd0);
    wait_idle(400);

    // Table: single-track changes, including a change back to zero
    reset_dut();
    foreach (vecs[k]) begin
      d0 = done_count;
      set_track(vecs[k].trk, vecs[k].note);
      expect_frame(vecs[k].byt);
      wait_idle(400);
      chk("vec_done_pulse", 32'(done_count - d0), 32'd1);
    end

    // Change then revert before launch is impossible while idle; revert during a frame instead
    d0 = done_count;
    t2 = 6'h11;
    expect_frame(8'h91);
    repeat (8) @(negedge clk);
    t1 = 6'h00;
    repeat (4) @(negedge clk);
    t1 = 6'h3F;
    wait_idle(400);
    chk("revert_no_frame", 32'(done_count - d0), 32'd1);

    // 6: reset mid-frame aborts and the track is resent after release
    reset_dut();
    d0 = done_count;
    f0 = frame_count;
    t0 = 6'd7;
    expect_frame(8'h07);
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_idle(400);
    chk("abort_resent_done", 32'(done_count - d0), 32'd1);
    chk("abort_resent_frames", 32'(frame_count - f0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
